// File: rtl/arq_sender.sv
// rtl/arq_sender.sv - stop-and-wait ARQ transmitter, serial framing with retry (optional parity: ARQ_SENDER_PARITY_EN)
module arq_sender #(
    parameter int TIMEOUT   = 16,
    parameter int MAX_RETRY = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tx_bit,
    output logic       tx_en,
    input  logic       ack_valid,
    input  logic       ack_seq,
    output logic       busy,
    output logic       sent,
    output logic       fail
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

`ifdef ARQ_SENDER_PARITY_EN
    localparam int FL = 10;
`else
    localparam int FL = 9;
`endif

    localparam logic [3:0] LAST_BIT   = 4'(FL - 1);
    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);
    localparam logic [3:0] RETRY_LAST = 4'(MAX_RETRY);

    state_t      state_q, state_d;
    logic        seq_q, seq_d;
    logic [7:0]  data_q, data_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  timer_q, timer_d;
    logic [3:0]  retry_cnt_q, retry_cnt_d;
    logic        tx_bit_q, tx_bit_d;
    logic        tx_en_q, tx_en_d;
    logic        sent_q, sent_d;
    logic        fail_q, fail_d;
    logic        ack_match;

    // Frame bit idx: sequence bit first, then data MSB..LSB, then optional even parity
    function automatic logic frame_bit(input logic s, input logic [7:0] d, input logic [3:0] idx);
        logic b;
        case (idx)
            4'd0:    b = s;
            4'd1:    b = d[7];
            4'd2:    b = d[6];
            4'd3:    b = d[5];
            4'd4:    b = d[4];
            4'd5:    b = d[3];
            4'd6:    b = d[2];
            4'd7:    b = d[1];
            4'd8:    b = d[0];
`ifdef ARQ_SENDER_PARITY_EN
            4'd9:    b = ^d;
`endif
            default: b = 1'b0;
        endcase
        return b;
    endfunction

    assign ack_match = ack_valid && (ack_seq == seq_q);

    assign in_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign tx_bit   = tx_bit_q;
    assign tx_en    = tx_en_q;
    assign sent     = sent_q;
    assign fail     = fail_q;

    // Next-state logic; serial outputs are computed one cycle ahead so they leave a flop
    always_comb begin
        state_d     = state_q;
        seq_d       = seq_q;
        data_d      = data_q;
        bit_cnt_d   = bit_cnt_q;
        timer_d     = timer_q;
        retry_cnt_d = retry_cnt_q;
        tx_bit_d    = 1'b0;
        tx_en_d     = 1'b0;
        sent_d      = 1'b0;
        fail_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d      = in_data;
                    bit_cnt_d   = 4'd0;
                    retry_cnt_d = 4'd0;
                    state_d     = SEND;
                    tx_en_d     = 1'b1;
                    tx_bit_d    = frame_bit(seq_q, in_data, 4'd0);
                end
            end

            SEND: begin
                // bit_cnt_q is the index of the bit currently on tx_bit
                if (bit_cnt_q == LAST_BIT) begin
                    state_d = WAIT;
                    timer_d = 8'd0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    tx_en_d   = 1'b1;
                    tx_bit_d  = frame_bit(seq_q, data_q, bit_cnt_q + 4'd1);
                end
            end

            WAIT: begin
                timer_d = timer_q + 8'd1;
                if (ack_match) begin
                    // A matching ack wins over a coincident timeout
                    sent_d  = 1'b1;
                    seq_d   = ~seq_q;
                    state_d = IDLE;
                end else if (timer_q == TIMER_LAST) begin
                    if (retry_cnt_q == RETRY_LAST) begin
                        fail_d  = 1'b1;
                        seq_d   = ~seq_q;
                        state_d = IDLE;
                    end else begin
                        retry_cnt_d = retry_cnt_q + 4'd1;
                        bit_cnt_d   = 4'd0;
                        state_d     = SEND;
                        tx_en_d     = 1'b1;
                        tx_bit_d    = frame_bit(seq_q, data_q, 4'd0);
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any frame without a sent/fail pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            seq_q       <= 1'b0;
            data_q      <= 8'd0;
            bit_cnt_q   <= 4'd0;
            timer_q     <= 8'd0;
            retry_cnt_q <= 4'd0;
            tx_bit_q    <= 1'b0;
            tx_en_q     <= 1'b0;
            sent_q      <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            seq_q       <= seq_d;
            data_q      <= data_d;
            bit_cnt_q   <= bit_cnt_d;
            timer_q     <= timer_d;
            retry_cnt_q <= retry_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_en_q     <= tx_en_d;
            sent_q      <= sent_d;
            fail_q      <= fail_d;
        end
    end

endmodule

// File: tb/tb_arq_sender.sv
// tb/tb_arq_sender.sv - directed self-checking bench for arq_sender
module tb_arq_sender;

    localparam int TIMEOUT   = 16;
    localparam int MAX_RETRY = 3;
`ifdef ARQ_SENDER_PARITY_EN
    localparam int FL = 10;
`else
    localparam int FL = 9;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       tx_bit;
    logic       tx_en;
    logic       ack_valid;
    logic       ack_seq;
    logic       busy;
    logic       sent;
    logic       fail;

    int checks = 0;
    int errors = 0;
    int edges;

    arq_sender #(
        .TIMEOUT   (TIMEOUT),
        .MAX_RETRY (MAX_RETRY)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .tx_bit    (tx_bit),
        .tx_en     (tx_en),
        .ack_valid (ack_valid),
        .ack_seq   (ack_seq),
        .busy      (busy),
        .sent      (sent),
        .fail      (fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_bit(input logic [7:0] d, input logic s, input int i);
        logic [7:0] dd;
        dd = d;
        if (i == 0) return s;
        if (i <= 8) return dd[8 - i];
        return ^dd;
    endfunction

    // Handshake one byte and check the whole serial frame; returns in the first WAIT cycle
    task automatic send_frame(input logic [7:0] d, input logic s, input string tag);
        in_data  = d;
        in_valid = 1'b1;
        check_eq({tag, "_rdy"}, 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check_eq({tag, "_busy"}, 32'(busy), 32'd1);
        check_eq({tag, "_nrdy"}, 32'(in_ready), 32'd0);
        for (int i = 0; i < FL; i++) begin
            check_eq($sformatf("%s_en%0d", tag, i), 32'(tx_en), 32'd1);
            check_eq($sformatf("%s_b%0d", tag, i), 32'(tx_bit), 32'(exp_bit(d, s, i)));
            step();
        end
        check_eq({tag, "_en_off"}, 32'(tx_en), 32'd0);
        check_eq({tag, "_wait"}, 32'(busy), 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        ack_valid = 1'b0;
        ack_seq   = 1'b0;
        step();
        step();
        step();
        rst = 1'b0;
        check_eq("rst_tx_bit", 32'(tx_bit), 32'd0);
        check_eq("rst_tx_en", 32'(tx_en), 32'd0);
        check_eq("rst_sent", 32'(sent), 32'd0);
        check_eq("rst_fail", 32'(fail), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_ready", 32'(in_ready), 32'd1);

        // Byte 0xA5 with seq 0, matching ack on the third WAIT cycle
        send_frame(8'hA5, 1'b0, "a5");
        step();
        step();
        ack_valid = 1'b1;
        ack_seq   = 1'b0;
        step();
        ack_valid = 1'b0;
        check_eq("a5_sent", 32'(sent), 32'd1);
        check_eq("a5_fail", 32'(fail), 32'd0);
        check_eq("a5_ready", 32'(in_ready), 32'd1);
        step();
        check_eq("a5_sent_1cyc", 32'(sent), 32'd0);

        // Byte 0x01 with seq 1; stale ack is ignored, matching ack completes
        send_frame(8'h01, 1'b1, "b01");
        ack_valid = 1'b1;
        ack_seq   = 1'b0;
        step();
        ack_valid = 1'b0;
        check_eq("b01_stale_sent", 32'(sent), 32'd0);
        check_eq("b01_stale_busy", 32'(busy), 32'd1);
        step();
        ack_valid = 1'b1;
        ack_seq   = 1'b1;
        step();
        ack_valid = 1'b0;
        check_eq("b01_sent", 32'(sent), 32'd1);
        check_eq("b01_ready", 32'(in_ready), 32'd1);
        step();

        // No ack: MAX_RETRY+1 identical frames, then a fail pulse
        in_data  = 8'h3C;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        edges = 0;
        for (int r = 0; r <= MAX_RETRY; r++) begin
            for (int i = 0; i < FL; i++) begin
                check_eq($sformatf("rt%0d_en%0d", r, i), 32'(tx_en), 32'd1);
                check_eq($sformatf("rt%0d_b%0d", r, i), 32'(tx_bit), 32'(exp_bit(8'h3C, 1'b0, i)));
                step();
                edges++;
            end
            for (int t = 0; t < TIMEOUT; t++) begin
                check_eq($sformatf("rt%0d_gap%0d", r, t), 32'(tx_en), 32'd0);
                check_eq($sformatf("rt%0d_nofail%0d", r, t), 32'(fail), 32'd0);
                check_eq($sformatf("rt%0d_nrdy%0d", r, t), 32'(in_ready), 32'd0);
                step();
                edges++;
            end
        end
        check_eq("rt_fail", 32'(fail), 32'd1);
        check_eq("rt_fail_sent", 32'(sent), 32'd0);
        check_eq("rt_ready", 32'(in_ready), 32'd1);
        check_eq("rt_edges", 32'(edges), 32'((MAX_RETRY + 1) * (FL + TIMEOUT)));
        step();
        check_eq("rt_fail_1cyc", 32'(fail), 32'd0);

        // Reset during bit 4 of a seq-1 frame
        in_data  = 8'h96;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("mr_b%0d", i), 32'(tx_bit), 32'(exp_bit(8'h96, 1'b1, i)));
            step();
        end
        check_eq("mr_en_bit4", 32'(tx_en), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("mr_tx_en", 32'(tx_en), 32'd0);
        check_eq("mr_busy", 32'(busy), 32'd0);
        check_eq("mr_sent", 32'(sent), 32'd0);
        check_eq("mr_fail", 32'(fail), 32'd0);
        step();
        check_eq("mr_sent2", 32'(sent), 32'd0);
        check_eq("mr_fail2", 32'(fail), 32'd0);

        // seq restarts at 0; ack arrives exactly on the timeout cycle
        send_frame(8'h5A, 1'b0, "to");
        for (int t = 0; t < TIMEOUT - 1; t++) step();
        ack_valid = 1'b1;
        ack_seq   = 1'b0;
        step();
        ack_valid = 1'b0;
        check_eq("to_sent", 32'(sent), 32'd1);
        check_eq("to_fail", 32'(fail), 32'd0);
        check_eq("to_no_resend", 32'(tx_en), 32'd0);
        check_eq("to_ready", 32'(in_ready), 32'd1);
        step();
        check_eq("to_no_resend2", 32'(tx_en), 32'd0);
        check_eq("to_fail2", 32'(fail), 32'd0);

        // Idle reset, then 0xFF with seq 0
        rst = 1'b1;
        step();
        rst = 1'b0;
        send_frame(8'hFF, 1'b0, "ff");
        ack_valid = 1'b1;
        ack_seq   = 1'b0;
        step();
        ack_valid = 1'b0;
        check_eq("ff_sent", 32'(sent), 32'd1);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/arq_sender.md
# arq_sender

Stop-and-wait ARQ transmitter for the reliable-data link. Accepts one byte at a time from the producer through a valid/ready handshake. Frames each byte with a 1-bit sequence number and an optional even-parity bit, then shifts the frame out serially one bit per clock. Waits for a matching acknowledgement from the receiver side of `main`, retransmitting on timeout up to a retry limit.

## Interface
Parameters:
- `TIMEOUT`, 16 — number of WAIT cycles without a matching ack before a retransmit; must be 1..255.
- `MAX_RETRY`, 3 — number of retransmissions after the first send before giving up; must be 0..15.

Ports:
- `clk` in 1 — single clock, rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `in_data` in 8 — byte to send; sampled when `in_valid & in_ready`.
- `in_valid` in 1 — producer has a byte.
- `in_ready` out 1 — block can accept; equals (state == IDLE).
- `tx_bit` out 1 — serial frame bit; registered.
- `tx_en` out 1 — high on every cycle `tx_bit` carries a frame bit; registered.
- `ack_valid` in 1 — single-cycle acknowledgement strobe from the receiver.
- `ack_seq` in 1 — sequence number being acknowledged.
- `busy` out 1 — high whenever state != IDLE.
- `sent` out 1 — one-cycle pulse when the current byte is acknowledged.
- `fail` out 1 — one-cycle pulse when the retry limit is exhausted.

## Operation
- Registers:
  - `seq` (1 b, reset 0)
  - `data_q` (8 b)
  - `bit_cnt` (4 b)
  - `timer` (8 b)
  - `retry_cnt` (4 b)
- Frame order, first bit out first:
  - `seq`
  - `data_q[7]` down to `data_q[0]`
  - parity = XOR of `data_q` (even parity over the data bits only), when enabled.
  - Frame length FL = 10 with parity, 9 without.
- FSM states: IDLE, SEND, WAIT.
- IDLE:
  - On `in_valid`, latch `in_data`, clear `bit_cnt` and `retry_cnt`, go to SEND.
- SEND:
  - `tx_en`=1 and `tx_bit` = frame bit `bit_cnt`.
  - After FL cycles, go to WAIT with `timer`=0.
  - `ack_valid` is ignored in SEND.
- WAIT:
  - `timer` increments every cycle.
  - On `ack_valid & (ack_seq == seq)`: pulse `sent`, toggle `seq`, go to IDLE.
  - On `ack_valid` with a mismatched `ack_seq`: the ack is ignored.
  - Timeout (`timer == TIMEOUT-1` and no matching ack this cycle):
    - If `retry_cnt == MAX_RETRY`: pulse `fail`, toggle `seq`, go to IDLE.
    - Otherwise: increment `retry_cnt`, clear `bit_cnt`, go to SEND and resend the identical frame with the same `seq`.
- Simultaneous matching ack and timeout: the ack wins; no retransmit, no `fail`.
- `in_valid` while busy: not accepted (`in_ready`=0); the producer must hold its data.
- Reset mid-frame:
  - Next state is IDLE, `tx_en` drops on the following edge, and the partial frame is abandoned.
  - `seq`, `retry_cnt` and `timer` return to 0.
  - No `sent` or `fail` pulse is generated.

## Timing
- Reset values:
  - `tx_bit`=0, `tx_en`=0, `sent`=0, `fail`=0, `busy`=0.
  - `in_ready`=1 once `rst` is deasserted.
- Handshake on edge N (`in_valid & in_ready`):
  - `tx_en` is high for cycles N+1 .. N+FL.
  - `busy` is high from N+1.
  - `in_ready` is low from N+1.
- WAIT is occupied from cycle N+FL+1.
- Matching ack at WAIT cycle k:
  - `sent` is high on cycle k+1.
  - `in_ready` is high on cycle k+1.
  - A new byte can be accepted at the edge ending cycle k+1.
- No ack:
  - The retransmit's first bit appears TIMEOUT cycles after the last bit of the previous frame, plus one cycle.
- Worst-case occupancy per byte:
  - (MAX_RETRY+1)·(FL+TIMEOUT) cycles.
  - `fail` is high on the cycle after the final timeout.
- `sent` and `fail` are never high together; each is exactly one cycle wide.

## Configuration
- Macro: `ARQ_SENDER_PARITY_EN`.
- Defined: FL=10, and the trailing even-parity bit is appended to every frame.
- Undefined: FL=9, no parity bit, and all FL-dependent timing shrinks by one cycle. All other behaviour is identical.

## Test plan
- Reset, then `in_data`=0xA5 with `seq`=0 and parity enabled → `tx_bit` sequence 0,1,0,1,0,0,1,0,1,0 over 10 cycles with `tx_en`=1. Matching ack (`ack_seq`=0) on WAIT cycle 3 → `sent` pulse, `in_ready`=1, `seq`=1.
- Second byte 0x01 after the above → frame 1,0,0,0,0,0,0,0,1,1. Ack with `ack_seq`=0 is ignored; ack with `ack_seq`=1 gives `sent`.
- No ack, TIMEOUT=16, MAX_RETRY=3 → four identical frames, each 16 cycles apart after its last bit. `fail` pulse 104 cycles after the handshake; `seq` toggled.
- Matching ack on exactly the timeout cycle → `sent` asserted, no retransmit, `fail` stays 0.
- `rst` asserted during bit 4 of a frame → `tx_en`=0, `busy`=0, `seq`=0 on the next cycle. No `sent` or `fail` pulse.
- `ARQ_SENDER_PARITY_EN` undefined, 0xFF with `seq`=0 → 9-bit frame 0,1,1,1,1,1,1,1,1; WAIT entered after 9 cycles.
